// File: rtl/hash_stream_pkg.sv
// Shared definitions for the hash stream transmitter: default buffer depth
// and the streaming FSM state encoding.
package hash_stream_pkg;

    localparam int DEPTH_DEFAULT = 64;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_RTR,
        SEND,
        GAP,
        EOF_WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/hash_byte_buf.sv
// Byte buffer: DEPTH x 8 storage appended at the count, read by index with a
// registered read port, cleared in one cycle without touching the memory.
module hash_byte_buf
    import hash_stream_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clear,
    input  logic [AW-1:0] rd_idx,
    output logic [7:0]    rd_data,
    output logic [CW-1:0] count,
    output logic          full
);

    logic [7:0]    mem [DEPTH];
    logic [7:0]    rd_data_reg;
    logic [CW-1:0] count_reg;
    logic          full_reg;
    logic          accept;

    assign accept = wr_en && !full_reg;

    // Memory has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[count_reg[AW-1:0]] <= wr_data;
        end
        rd_data_reg <= mem[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            full_reg  <= 1'b0;
        end else if (clear) begin
            count_reg <= '0;
            full_reg  <= 1'b0;
        end else if (accept) begin
            count_reg <= count_reg + 1'b1;
            full_reg  <= (count_reg == CW'(DEPTH - 1));
        end
    end

    assign rd_data = rd_data_reg;
    assign count   = count_reg;
    assign full    = full_reg;

endmodule

// File: rtl/hash_stream_tx.sv
// Producer side of the start/Byte/F_dr/F_rtr/End_of_File/H_ready/R_h hasher
// handshake: buffers host bytes, streams them on request, captures the digest.
module hash_stream_tx
    import hash_stream_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic [$clog2(DEPTH):0]   buf_count,
    output logic                     buf_full,
    input  logic                     go,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              digest,
    output logic                     start,
    output logic [7:0]               Byte,
    output logic                     F_dr,
    output logic                     End_of_File,
    input  logic                     F_rtr,
    input  logic                     H_ready,
    input  logic [31:0]              R_h
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_t        state_reg;
    logic [CW-1:0] length_reg;
    logic [CW-1:0] index_reg;
    logic          start_reg;
    logic          f_dr_reg;
    logic          eof_reg;
    logic          done_reg;
    logic          busy_reg;
    logic [7:0]    byte_reg;
    logic [31:0]   digest_reg;

    logic          buf_wr;
    logic          buf_clear;
    logic [7:0]    buf_rd_data;

    // Host writes only land while idle, and a write coinciding with go is dropped.
    assign buf_wr    = wr_en && !go && (state_reg == IDLE);
    assign buf_clear = (state_reg == EOF_WAIT) && H_ready;

    hash_byte_buf #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (buf_wr),
        .wr_data (wr_data),
        .clear   (buf_clear),
        .rd_idx  (index_reg[AW-1:0]),
        .rd_data (buf_rd_data),
        .count   (buf_count),
        .full    (buf_full)
    );

    // The read port is registered; index is stable for a full cycle before
    // every WAIT_RTR, so buf_rd_data already holds buffer[index] there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            length_reg <= '0;
            index_reg  <= '0;
            start_reg  <= 1'b0;
            f_dr_reg   <= 1'b0;
            eof_reg    <= 1'b0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            byte_reg   <= 8'h00;
            digest_reg <= 32'h0000_0000;
        end else begin
            start_reg <= 1'b0;
            f_dr_reg  <= 1'b0;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (go) begin
                        length_reg <= buf_count;
                        index_reg  <= '0;
                        start_reg  <= 1'b1;
                        busy_reg   <= 1'b1;
                        state_reg  <= START;
                    end
                end
                START: begin
                    if (length_reg != '0) begin
                        state_reg <= WAIT_RTR;
                    end else begin
                        eof_reg   <= 1'b1;
                        state_reg <= EOF_WAIT;
                    end
                end
                WAIT_RTR: begin
                    if (F_rtr) begin
                        f_dr_reg  <= 1'b1;
                        byte_reg  <= buf_rd_data;
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    index_reg <= index_reg + 1'b1;
                    state_reg <= GAP;
                end
                GAP: begin
                    if (index_reg < length_reg) begin
                        state_reg <= WAIT_RTR;
                    end else begin
                        eof_reg   <= 1'b1;
                        state_reg <= EOF_WAIT;
                    end
                end
                EOF_WAIT: begin
                    if (H_ready) begin
                        digest_reg <= R_h;
                        eof_reg    <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign digest      = digest_reg;
    assign start       = start_reg;
    assign Byte        = byte_reg;
    assign F_dr        = f_dr_reg;
    assign End_of_File = eof_reg;

endmodule

// File: tb/tb_hash_stream_tx.sv
// Randomized bench for hash_stream_tx: a queue model of the host buffer and a
// hasher responder with configurable F_rtr gaps and H_ready delay.
module tb_hash_stream_tx;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        go = 1'b0;
    logic        F_rtr = 1'b1;
    logic        H_ready = 1'b0;
    logic [31:0] R_h = 32'h0;

    logic [$clog2(DEPTH):0] buf_count;
    logic        buf_full;
    logic        busy;
    logic        done;
    logic [31:0] digest;
    logic        start;
    logic [7:0]  Byte;
    logic        F_dr;
    logic        End_of_File;

    hash_stream_tx #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .buf_count   (buf_count),
        .buf_full    (buf_full),
        .go          (go),
        .busy        (busy),
        .done        (done),
        .digest      (digest),
        .start       (start),
        .Byte        (Byte),
        .F_dr        (F_dr),
        .End_of_File (End_of_File),
        .F_rtr       (F_rtr),
        .H_ready     (H_ready),
        .R_h         (R_h)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model and monitor state
    logic [7:0]  model_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  last_byte = 8'h00;
    logic [31:0] rh_val = 32'h0;
    logic [31:0] exp_digest = 32'h0;
    int cyc = 0, last_dr = 0, start_cnt = 0;
    int gap_err = 0, hold_err = 0, rtr_err = 0;
    int eof_cnt = 0, rtr_cnt = 0, rtr_gap = 0, hr_delay = 5;
    bit have_last = 1'b0, eof_seen = 1'b0;

    // Monitor plus hasher responder, all on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            rtr_cnt = 0;
            eof_cnt = 0;
            H_ready = 1'b0;
            F_rtr   = 1'b1;
        end else begin
            if (start) begin
                start_cnt++;
                rtr_cnt = rtr_gap;
            end
            if (F_dr) begin
                if (!F_rtr) rtr_err++;
                if (have_last && (cyc - last_dr) < 2) gap_err++;
                have_last = 1'b1;
                last_dr   = cyc;
                got_q.push_back(Byte);
                last_byte = Byte;
                rtr_cnt   = rtr_gap;
            end else if (Byte !== last_byte) begin
                hold_err++;
            end
            if (End_of_File) begin
                eof_seen = 1'b1;
                eof_cnt++;
            end else begin
                eof_cnt = 0;
            end
            H_ready = End_of_File && (eof_cnt == hr_delay);
            R_h     = H_ready ? rh_val : $urandom;
            if (rtr_cnt > 0) begin
                rtr_cnt--;
                F_rtr = 1'b0;
            end else begin
                F_rtr = 1'b1;
            end
        end
    end

    task automatic write_byte(input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(d);
        check("buf_count", 32'(buf_count), model_q.size());
        check("buf_full", 32'(buf_full), 32'(model_q.size() == DEPTH));
    endtask

    task automatic run_stream(input int gap, input int hrd, input logic [31:0] rh, input bit poke);
        logic [7:0] exp_q[$];
        int  len;
        bit  ok;
        exp_q = model_q;
        len   = exp_q.size();
        got_q.delete();
        start_cnt = 0; gap_err = 0; hold_err = 0; rtr_err = 0;
        have_last = 1'b0; eof_seen = 1'b0;
        rtr_gap = gap; hr_delay = hrd; rh_val = rh;
        last_byte = Byte;
        check("digest_hold", digest, exp_digest);
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("start_lat", 32'(start), 1);
        check("busy_run", 32'(busy), 1);
        if (gap == 0 && len > 0) begin
            @(negedge clk);
            check("fdr_n2", 32'(F_dr), 0);
            @(negedge clk);
            check("fdr_n3", 32'(F_dr), 1);
        end
        if (len == 0) begin
            @(negedge clk);
            check("eof_empty", 32'(End_of_File), 1);
        end
        if (poke) begin
            @(negedge clk);
            wr_en = 1'b1; go = 1'b1; wr_data = 8'($urandom);
            @(negedge clk);
            wr_en = 1'b0; go = 1'b0;
            check("cnt_busy", 32'(buf_count), len);
        end
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", 32'(ok), 1);
        if (ok) begin
            exp_digest = rh;
            check("digest", digest, rh);
            check("cnt_clr", 32'(buf_count), 0);
            check("busy_done", 32'(busy), 1);
            @(negedge clk);
            check("done_pulse", 32'(done), 0);
            check("idle", 32'(busy), 0);
            check("eof_low", 32'(End_of_File), 0);
        end
        check("n_bytes", got_q.size(), len);
        for (int i = 0; i < len && i < got_q.size(); i++)
            check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        check("start_cnt", start_cnt, 1);
        check("fdr_space", gap_err, 0);
        check("byte_hold", hold_err, 0);
        check("rtr_order", rtr_err, 0);
        check("eof_seen", 32'(eof_seen), 1);
        $display("run len=%0d gap=%0d hr_delay=%0d poke=%0d digest=%h bytes_seen=%0d",
                 len, gap, hrd, poke, digest, got_q.size());
        model_q.delete();
    endtask

    initial begin
        string s;
        int n;
        bit found;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_cnt", 32'(buf_count), 0);
        check("rst_fdr", 32'(F_dr), 0);
        check("rst_byte", 32'(Byte), 0);
        check("rst_digest", digest, 0);
        check("rst_eof", 32'(End_of_File), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_full", 32'(buf_full), 0);

        s = "CiaoMondo";
        for (int i = 0; i < s.len(); i++) write_byte(s[i]);
        run_stream(0, 5, 32'hDEADBEEF, 1'b0);

        run_stream(0, 5, 32'h12345678, 1'b0);

        for (int i = 0; i <= 64; i++) write_byte(8'(i));
        run_stream(0, 3, $urandom, 1'b0);

        for (int i = 0; i < 3; i++) write_byte(8'($urandom));
        run_stream(20, 2, $urandom, 1'b0);

        for (int i = 0; i < 5; i++) write_byte(8'($urandom));
        run_stream(3, 4, $urandom, 1'b1);

        repeat (6) begin
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) write_byte(8'($urandom));
            run_stream($urandom_range(0, 3), $urandom_range(1, 8), $urandom, 1'b0);
        end

        // Reset in the middle of a 9-byte stream
        for (int i = 0; i < 9; i++) write_byte(8'($urandom));
        rtr_gap = 0;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (F_dr) n++;
            if (n == 4) begin
                found = 1'b1;
                break;
            end
        end
        check("fourth_byte", 32'(found), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_fdr", 32'(F_dr), 0);
        check("mid_rst_eof", 32'(End_of_File), 0);
        check("mid_rst_start", 32'(start), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_cnt", 32'(buf_count), 0);
        check("mid_rst_digest", digest, 0);
        $display("reset mid-stream after %0d bytes", n);
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        exp_digest = 32'h0;
        for (int i = 0; i < 2; i++) write_byte(8'($urandom));
        run_stream(0, 2, $urandom, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
